// File: rtl/io_handshake_port.sv
// io_handshake_port
//   Input-side bridge in front of the processor's bus_in/hs_in/hs_out port.
//   Bytes arrive from an external producer over valid/ready. They are buffered
//   in a small FIFO and offered to the processor one at a time with a
//   four-phase req/ack handshake.
//
// Ports
//   g_clk      clock, rising edge
//   g_clr      asynchronous active-low global clear
//   src_data   byte from external source
//   src_valid  src_data valid this cycle
//   src_ready  FIFO can accept (== !full)
//   bus_out    registered byte presented to the processor
//   hs_out     registered request to the processor
//   hs_in      acknowledge from the processor
//   count      registered FIFO occupancy
//   full       count == depth
//   empty      count == 0
//   err_clr    synchronous clear of proto_err
//   proto_err  sticky flag: acknowledge seen while no request was pending
module io_handshake_port #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int ptr_w = 2
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [width-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [width-1:0] bus_out,
  output logic             hs_out,
  input  logic             hs_in,
  output logic [ptr_w:0]   count,
  output logic             full,
  output logic             empty,
  input  logic             err_clr,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  localparam logic [ptr_w:0]   DEPTH_C   = (ptr_w + 1)'(depth);
  localparam logic [ptr_w:0]   CNT_ONE   = (ptr_w + 1)'(1);
  localparam logic [ptr_w-1:0] PTR_ONE   = ptr_w'(1);

  // Storage has no reset: contents are meaningless until written.
  logic [width-1:0] mem_q [depth];

  state_t           state_q, state_d;
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w:0]   count_q, count_d;
  logic [width-1:0] bus_out_q, bus_out_d;
  logic             hs_out_q, hs_out_d;
  logic             proto_err_q, proto_err_d;

  logic push;
  logic pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  // Taken from the registered count, so a push is refused in the cycle a
  // full FIFO pops.
  assign src_ready = !full;
  assign push      = src_valid && src_ready;

  assign count     = count_q;
  assign bus_out   = bus_out_q;
  assign hs_out    = hs_out_q;
  assign proto_err = proto_err_q;

  // Handshake sequencing. pop is asserted on the edge the acknowledge is seen.
  always_comb begin
    state_d     = state_q;
    bus_out_d   = bus_out_q;
    hs_out_d    = hs_out_q;
    pop         = 1'b0;
    proto_err_d = proto_err_q;

    if (err_clr) begin
      proto_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Acknowledge with no outstanding request is a protocol violation;
        // it wins over a clear in the same cycle.
        if (hs_in) begin
          proto_err_d = 1'b1;
        end
        if (!empty) begin
          bus_out_d = mem_q[rd_ptr_q];
          hs_out_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (hs_in) begin
          hs_out_d = 1'b0;
          pop      = 1'b1;
          state_d  = ACK_LOW;
        end
      end
      ACK_LOW: begin
        // count already reflects the pop, so rd_ptr points at the next byte.
        if (!hs_in) begin
          if (!empty) begin
            bus_out_d = mem_q[rd_ptr_q];
            hs_out_d  = 1'b1;
            state_d   = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        hs_out_d = 1'b0;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= src_data;
    end
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_out_q   <= '0;
      hs_out_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bus_out_q   <= bus_out_d;
      hs_out_q    <= hs_out_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_io_handshake_port.sv
// tb_io_handshake_port
//   Drives io_handshake_port with directed and random traffic and compares
//   every cycle against a queue-based behavioural model of the port.
module tb_io_handshake_port;

  logic       g_clk;
  logic       g_clr;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] bus_out;
  logic       hs_out;
  logic       hs_in;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       err_clr;
  logic       proto_err;

  io_handshake_port #(.width(8), .depth(4), .ptr_w(2)) dut (
    .g_clk     (g_clk),
    .g_clr     (g_clr),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .bus_out   (bus_out),
    .hs_out    (hs_out),
    .hs_in     (hs_in),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err_clr   (err_clr),
    .proto_err (proto_err)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: bytes accepted but not yet acknowledged, plus the
  // visible handshake outputs.
  logic [7:0] m_q[$];
  logic [7:0] popped[$];
  logic       m_hs;
  logic       m_await;   // ack taken, waiting for the processor to drop it
  logic [7:0] m_bus;
  logic       m_err;
  int         m_wr;
  int         m_rd;
  int         max_cnt;

  int         ack_pct = 100;
  bit         man_ack = 0;

  task automatic model_reset();
    m_q.delete();
    m_hs    = 1'b0;
    m_await = 1'b0;
    m_bus   = 8'h00;
    m_err   = 1'b0;
    m_wr    = 0;
    m_rd    = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".hs_out"},    {31'd0, hs_out},    {31'd0, m_hs});
    chk({tag, ".bus_out"},   {24'd0, bus_out},   {24'd0, m_bus});
    chk({tag, ".count"},     {29'd0, count},     m_q.size());
    chk({tag, ".full"},      {31'd0, full},      {31'd0, m_q.size() == 4});
    chk({tag, ".empty"},     {31'd0, empty},     {31'd0, m_q.size() == 0});
    chk({tag, ".src_ready"}, {31'd0, src_ready}, {31'd0, m_q.size() != 4});
    chk({tag, ".proto_err"}, {31'd0, proto_err}, {31'd0, m_err});
  endtask

  // One clock: choose ack (unless manual), predict, clock, compare.
  task automatic tick();
    int  pre;
    bit  idle;
    bit  do_push;
    bit  do_pop;
    if (!man_ack) begin
      if (m_hs && !hs_in && ($urandom_range(99) < ack_pct)) hs_in = 1'b1;
      else if (!m_hs && hs_in && ($urandom_range(99) < ack_pct)) hs_in = 1'b0;
    end
    pre     = m_q.size();
    idle    = !m_hs && !m_await;
    do_push = src_valid && (pre < 4);
    do_pop  = m_hs && hs_in;
    if (idle && hs_in) m_err = 1'b1;
    else if (err_clr)  m_err = 1'b0;
    if (m_hs) begin
      if (hs_in) begin
        m_hs    = 1'b0;
        m_await = 1'b1;
      end
    end else if (m_await) begin
      if (!hs_in) begin
        m_await = 1'b0;
        if (pre > 0) begin
          m_hs  = 1'b1;
          m_bus = m_q[0];
        end
      end
    end else if (pre > 0) begin
      m_hs  = 1'b1;
      m_bus = m_q[0];
    end
    if (do_pop) begin
      popped.push_back(m_q.pop_front());
      m_rd = (m_rd + 1) % 4;
    end
    if (do_push) begin
      m_q.push_back(src_data);
      m_wr = (m_wr + 1) % 4;
    end
    if (m_q.size() > max_cnt) max_cnt = m_q.size();
    @(posedge g_clk);
    @(negedge g_clk);
    check_outputs("cyc");
    $display("t=%0t push=%0b data=%02h hs_in=%0b -> hs_out=%0b bus=%02h count=%0d err=%0b",
             $time, do_push, src_data, hs_in, hs_out, bus_out, count, proto_err);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    src_valid = 1'b0;
    ack_pct   = 100;
    man_ack   = 0;
    while ((m_q.size() != 0 || m_hs || m_await) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, (m_q.size() != 0 || m_hs || m_await)}, 32'd0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    src_valid = 1'b0;
    while (!m_hs && n < budget) begin
      tick();
      n++;
    end
    chk("req_timeout", {31'd0, m_hs}, 32'd1);
  endtask

  initial begin
    int idx;
    int n;
    src_data  = 8'h00;
    src_valid = 1'b0;
    hs_in     = 1'b0;
    err_clr   = 1'b0;
    max_cnt   = 0;
    model_reset();

    // Reset
    g_clr = 1'b1;
    #1 g_clr = 1'b0;
    #2 check_outputs("reset");
    repeat (2) @(negedge g_clk);
    g_clr = 1'b1;
    @(negedge g_clk);
    check_outputs("post_reset");

    // Single byte, ideal acknowledger
    src_valid = 1'b1; src_data = 8'h5A;
    tick();
    src_valid = 1'b0;
    chk("lat_edge1_hs", {31'd0, hs_out}, 32'd0);
    tick();
    chk("lat_edge2_hs", {31'd0, hs_out}, 32'd1);
    chk("lat_edge2_bus", {24'd0, bus_out}, 32'h5A);
    drain(20);
    chk("single_pops", popped.size(), 32'd1);
    if (popped.size() == 1) chk("single_val", {24'd0, popped[0]}, 32'h5A);
    chk("single_count", {29'd0, count}, 32'd0);

    // Fill to full with no acknowledge, then a refused fifth push
    popped.delete();
    ack_pct = 0;
    for (int i = 1; i <= 4; i++) begin
      src_valid = 1'b1; src_data = 8'(i);
      tick();
    end
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ready", {31'd0, src_ready}, 32'd0);
    src_data = 8'h05;
    tick();
    chk("refuse_count", {29'd0, count}, 32'd4);
    drain(40);
    chk("fill_pops", popped.size(), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("fill_order", {24'd0, popped[i]}, i + 1);

    // Streaming through pointer wrap while draining
    popped.delete();
    max_cnt = 0;
    ack_pct = 100;
    idx = 0;
    n = 0;
    while ((idx < 6 || m_q.size() != 0 || m_hs || m_await) && n < 80) begin
      if (idx < 6 && m_q.size() < 4) begin
        src_valid = 1'b1; src_data = 8'h10 + 8'(idx); idx++;
      end else begin
        src_valid = 1'b0;
      end
      tick();
      n++;
    end
    chk("stream_pops", popped.size(), 32'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      chk("stream_order", {24'd0, popped[i]}, 32'h10 + i);
    chk("stream_max_le4", {31'd0, max_cnt <= 4}, 32'd1);

    // Push and pop in the same cycle at count=2
    popped.delete();
    ack_pct = 0;
    src_valid = 1'b1; src_data = 8'hA0; tick();
    src_data = 8'hA1; tick();
    wait_req(10);
    begin
      int exp_rd;
      int exp_wr;
      exp_rd = (m_rd + 1) % 4;
      exp_wr = (m_wr + 1) % 4;
      man_ack = 1;
      hs_in = 1'b1; src_valid = 1'b1; src_data = 8'hA2;
      tick();
      chk("pp_count", {29'd0, count}, 32'd2);
      chk("pp_rd_ptr", {30'd0, dut.rd_ptr_q}, exp_rd);
      chk("pp_wr_ptr", {30'd0, dut.wr_ptr_q}, exp_wr);
    end
    drain(40);
    chk("pp_pops", popped.size(), 32'd3);

    // Asynchronous clear in REQ with three bytes queued
    ack_pct = 0;
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1; src_data = 8'hC0 + 8'(i); tick();
    end
    wait_req(10);
    chk("clr_pre_count", {29'd0, count}, 32'd3);
    #2 g_clr = 1'b0;
    #1;
    model_reset();
    chk("clr_hs_out", {31'd0, hs_out}, 32'd0);
    chk("clr_bus_out", {24'd0, bus_out}, 32'd0);
    chk("clr_count", {29'd0, count}, 32'd0);
    g_clr = 1'b1;
    @(negedge g_clk);
    ack_pct = 100;
    for (int i = 0; i < 5; i++) tick();
    chk("clr_no_req", {31'd0, hs_out}, 32'd0);

    // Protocol error flag
    man_ack = 1;
    hs_in = 1'b1; tick();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_count", {29'd0, count}, 32'd0);
    hs_in = 1'b0; err_clr = 1'b1; tick();
    chk("perr_clr", {31'd0, proto_err}, 32'd0);
    hs_in = 1'b1; err_clr = 1'b1; tick();
    chk("perr_set_wins", {31'd0, proto_err}, 32'd1);
    hs_in = 1'b0; tick();
    err_clr = 1'b0; tick();
    man_ack = 0;

    // Random traffic
    popped.delete();
    max_cnt = 0;
    for (int seg = 0; seg < 8; seg++) begin
      ack_pct = $urandom_range(90, 20);
      for (int i = 0; i < 50; i++) begin
        src_valid = ($urandom_range(99) < 60);
        src_data  = 8'($urandom);
        tick();
      end
    end
    drain(60);
    chk("rand_max_le4", {31'd0, max_cnt <= 4}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_handshake_port.md
Name: io_handshake_port

Overview:
- Input-side peripheral bridge that sits directly upstream of the processor's bus_in/hs_in/hs_out interface.
- Accepts bytes from an external source over a valid/ready interface and buffers them in a small FIFO.
- Presents each byte to the processor's RIN path using a four-phase req/ack handshake.
- Decouples bursty external producers from the processor's instruction-paced input reads.

Parameters:
- width, 8, data byte width; must match the processor bus_in width.
- depth, 4, FIFO entries; must be a power of two, minimum 2.
- ptr_w, 2, pointer width, log2(depth); count width is ptr_w+1.

Ports:
- g_clk  input  1  clock; all state changes on the rising edge.
- g_clr  input  1  global clear; asynchronous, active-low.
- src_data  input  width  byte from the external source.
- src_valid  input  1  src_data is valid this cycle.
- src_ready  output  1  FIFO can accept; combinational, equal to !full.
- bus_out  output  width  byte to the processor bus_in; registered.
- hs_out  output  1  request to the processor hs_in; registered.
- hs_in  input  1  acknowledge from the processor hs_out.
- count  output  ptr_w+1  current FIFO occupancy; registered.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- err_clr  input  1  synchronous clear of proto_err.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (g_clr=0, asynchronous, takes effect immediately including mid-handshake):
  - hs_out=0, bus_out=0, count=0, both pointers=0, proto_err=0, state=IDLE.
  - FIFO contents are don't-care.
- Push:
  - src_valid & src_ready writes src_data at wr_ptr; wr_ptr increments modulo depth (wraps depth-1 -> 0).
  - When full, src_ready=0 and src_valid is ignored; no write occurs and no data is corrupted.
- Handshake FSM states: IDLE, REQ, ACK_LOW.
- IDLE:
  - If !empty: load bus_out <= fifo[rd_ptr], set hs_out <= 1, go to REQ.
  - Otherwise hold. Data appears at most one cycle after count goes nonzero.
  - hs_in=1 sampled in IDLE sets proto_err and is otherwise ignored.
- REQ:
  - hs_out=1 and bus_out are held stable.
  - When hs_in=1 is sampled: hs_out <= 0, pop (rd_ptr increments modulo depth, count decrements), go to ACK_LOW.
  - bus_out keeps the popped value.
- ACK_LOW:
  - Wait for hs_in=0.
  - On hs_in=0, if !empty (after the pop): load the next byte, hs_out <= 1, go directly to REQ.
  - On hs_in=0 and empty: go to IDLE.
  - bus_out is unchanged while in ACK_LOW.
- Simultaneous push and pop in the same cycle: count unchanged and both pointers advance.
  - A push into an empty FIFO is not visible to IDLE until the next cycle; count is registered and there is no bypass.
  - A push in the same cycle a full FIFO pops is refused, because src_ready is taken from the registered full.
- Throughput:
  - Minimum 2 cycles per byte (REQ, ACK_LOW) with an ideal acknowledger.
  - Latency from first push into an empty FIFO to hs_out=1 is 2 rising edges.
- proto_err:
  - Set by hs_in=1 in IDLE.
  - Cleared synchronously by err_clr=1; set has priority over clear in the same cycle.
- count/full/empty are mutually consistent every cycle; full and empty may be derived combinationally from count.

Test Plan:
- Reset then push 0x5A, with the processor model acking 1 cycle after req and dropping ack 1 cycle after req falls -> hs_out rises 2 edges after push, bus_out=0x5A; pop on ack; count returns 0; FSM returns to IDLE.
- Push 0x01..0x04 back-to-back with hs_in held 0 -> count=4, full=1, src_ready=0; 5th push 0x05 refused; draining yields 0x01,0x02,0x03,0x04 in order with no 0x05.
- Six bytes 0x10..0x15 streamed while draining concurrently (pointer wrap) -> output order exactly 0x10..0x15; count never exceeds 4.
- Push and pop in the same cycle at count=2 -> count stays 2; rd_ptr and wr_ptr both advance by 1.
- g_clr pulsed low while in REQ with count=3 -> hs_out=0, bus_out=0, count=0 immediately without waiting for a clock; no byte is presented after release until a new push.
- hs_in=1 while IDLE and empty -> proto_err=1, no pop, count unchanged; err_clr=1 for one cycle -> proto_err=0; err_clr asserted in the same cycle as a new violation -> proto_err stays 1.
